// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with standard or first-word-fall-through read,
// occupancy count, almost-full/almost-empty thresholds, sticky error flags and
// a synchronous flush. Reset is asynchronous and active-low on port 'reset'.
module fifo_sync_param #(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr,
  input  logic [DW-1:0] data_in,
  input  logic          rd,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          clr_err
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_COUNT   = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_COUNT   = (AW+1)'(AE_LEVEL);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic rd_ok;
  logic wr_ok;
  logic rd_go;
  logic wr_go;
  logic ovf_event;
  logic unf_event;

  // A read is only accepted when there is data; a write into a full FIFO is
  // accepted when a read frees a slot in the same cycle. Flush kills both.
  assign rd_ok     = rd & ~empty;
  assign wr_ok     = wr & (~full | rd_ok);
  assign rd_go     = rd_ok & ~flush;
  assign wr_go     = wr_ok & ~flush;
  assign ovf_event = wr & ~wr_ok & ~flush;
  assign unf_event = rd & ~rd_ok & ~flush;

  // Status flags decoded from the registered occupancy count.
  assign full         = (count == FULL_COUNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_COUNT);
  assign almost_empty = (count <= AE_COUNT);

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy count; flush returns everything to the empty state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_go, rd_go})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as clr_err wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~clr_err) | ovf_event;
      underflow <= (underflow & ~clr_err) | unf_event;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DW-1:0] data_out_reg;
      logic          data_valid_reg;

      // Standard read: head is captured on an accepted read and flagged valid
      // for one cycle; otherwise the last value is held.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          data_out_reg   <= '0;
          data_valid_reg <= 1'b0;
        end else if (flush) begin
          data_valid_reg <= 1'b0;
        end else if (rd_go) begin
          data_out_reg   <= mem[rd_ptr];
          data_valid_reg <= 1'b1;
        end else begin
          data_valid_reg <= 1'b0;
        end
      end

      assign data_out   = data_out_reg;
      assign data_valid = data_valid_reg;
    end else begin : g_fwft_read
      // Fall-through read: the head entry is presented whenever the FIFO holds
      // data; an empty FIFO shows zero so reset leaves data_out at 0.
      assign data_out   = empty ? '0 : mem[rd_ptr];
      assign data_valid = ~empty;
    end
  endgenerate

endmodule
